// File: rtl/sd_spi_pkg.sv
// sd_spi_pkg: shared byte width and FSM state type for the SD SPI responder.
package sd_spi_pkg;
    localparam int BYTE_W = 8;
    typedef enum logic {IDLE, ACTIVE} state_t;
endpackage

// File: rtl/sd_spi_responder_if.sv
// sd_spi_responder_if: SPI pins plus byte-level tx/rx handshake of the responder.
interface sd_spi_responder_if;
    import sd_spi_pkg::*;
    logic              sclk;
    logic              cs_n;
    logic              mosi;
    logic              miso;
    logic [BYTE_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ack;
    logic [BYTE_W-1:0] rx_data;
    logic              rx_valid;
    modport slave (input sclk, cs_n, mosi, tx_data, tx_valid, output miso, tx_ack, rx_data, rx_valid);
    modport master (output sclk, cs_n, mosi, tx_data, tx_valid, input miso, tx_ack, rx_data, rx_valid);
endinterface

// File: rtl/spi_edge_sync.sv
// spi_edge_sync: 2-flop synchronizer plus one history flop for rise/fall detection.
module spi_edge_sync #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic n_rst,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);
    logic [2:0] sr;
    always_ff @(posedge clk or negedge n_rst)
        if (!n_rst) sr <= {3{RST_VAL}};
        else        sr <= {sr[1:0], d};
    assign q    = sr[1];
    assign rise = sr[1] & ~sr[2];
    assign fall = ~sr[1] & sr[2];
endmodule

// File: rtl/sd_spi_responder.sv
// sd_spi_responder: SPI mode-0 byte responder clocked entirely from the system clock.
module sd_spi_responder
    import sd_spi_pkg::*;
#(
    parameter logic [BYTE_W-1:0] FILL_BYTE = 8'hFF
) (
    input logic                clk,
    input logic                n_rst,
    sd_spi_responder_if.slave  bus
);
    state_t            state, state_nx;
    logic              cs_s, mosi_s, sclk_rise, sclk_fall;
    logic              sclk_unused_q, cs_unused_rise, cs_unused_fall, mosi_unused_rise, mosi_unused_fall;
    logic [2:0]        cnt;
    logic              load_pending, tx_ack, rx_valid;
    logic [BYTE_W-1:0] tx_sr, rx_data;
    logic [BYTE_W-2:0] rx_sr;
    logic              act, rise_act, fall_act, load, leave, wrap;

    spi_edge_sync #(.RST_VAL(1'b0)) u_sclk (.clk(clk), .n_rst(n_rst), .d(bus.sclk), .q(sclk_unused_q), .rise(sclk_rise), .fall(sclk_fall));
    spi_edge_sync #(.RST_VAL(1'b1)) u_cs   (.clk(clk), .n_rst(n_rst), .d(bus.cs_n), .q(cs_s), .rise(cs_unused_rise), .fall(cs_unused_fall));
    spi_edge_sync #(.RST_VAL(1'b1)) u_mosi (.clk(clk), .n_rst(n_rst), .d(bus.mosi), .q(mosi_s), .rise(mosi_unused_rise), .fall(mosi_unused_fall));

    always_ff @(posedge clk or negedge n_rst)
        if (!n_rst) state <= IDLE;
        else        state <= state_nx;

    always_comb state_nx = cs_s ? IDLE : ACTIVE;

    // Deselect wins over any sclk edge seen in the same cycle.
    always_comb begin
        act      = state == ACTIVE && !cs_s;
        leave    = state == ACTIVE && cs_s;
        rise_act = act && sclk_rise;
        fall_act = act && sclk_fall;
        wrap     = rise_act && cnt == 3'd7;
        load     = (state == IDLE && !cs_s) || (fall_act && load_pending);
    end

    always_ff @(posedge clk or negedge n_rst)
        if (!n_rst) begin
            tx_sr        <= '1;
            rx_sr        <= '1;
            rx_data      <= '0;
            cnt          <= '0;
            load_pending <= 1'b0;
            tx_ack       <= 1'b0;
            rx_valid     <= 1'b0;
        end else begin
            tx_ack   <= load && bus.tx_valid;
            rx_valid <= wrap;
            if (load)          tx_sr <= bus.tx_valid ? bus.tx_data : FILL_BYTE;
            else if (fall_act) tx_sr <= {tx_sr[BYTE_W-2:0], 1'b1};
            if (rise_act)      rx_sr <= {rx_sr[BYTE_W-3:0], mosi_s};
            if (wrap)          rx_data <= {rx_sr, mosi_s};
            if (leave)         cnt <= '0;
            else if (rise_act) cnt <= cnt + 3'd1;
            if (leave || fall_act) load_pending <= 1'b0;
            else if (wrap)         load_pending <= 1'b1;
        end

    assign bus.miso     = state == ACTIVE ? tx_sr[BYTE_W-1] : 1'b1;
    assign bus.tx_ack   = tx_ack;
    assign bus.rx_data  = rx_data;
    assign bus.rx_valid = rx_valid;
endmodule

// File: tb/tb_sd_spi_responder.sv
// tb_sd_spi_responder: directed SPI host with queued expectations checked by a negedge monitor.
module tb_sd_spi_responder;
    logic clk = 1'b0;
    logic n_rst = 1'b0;
    logic chk_rst = 1'b0;
    logic chk_end = 1'b0;
    int tests = 0;
    int fails = 0;
    logic [7:0] rx_q[$];
    logic [7:0] ack_q[$];
    logic       miso_q[$];

    sd_spi_responder_if bus();
    sd_spi_responder #(.FILL_BYTE(8'hFF)) dut (.clk(clk), .n_rst(n_rst), .bus(bus));

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, required finish before 2ms");
        $fatal(1);
    end

    task automatic check(input string nm, input logic [7:0] got, input logic [7:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h, required %h", nm, got, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [7:0] e;
        logic       b;
        if (chk_rst) begin
            check("rst_miso", {7'd0, bus.miso}, 8'h01);
            check("rst_rx_data", bus.rx_data, 8'h00);
            check("rst_tx_ack", {7'd0, bus.tx_ack}, 8'h00);
            check("rst_rx_valid", {7'd0, bus.rx_valid}, 8'h00);
        end
        if (bus.rx_valid) begin
            if (rx_q.size() == 0) begin
                tests++; fails++;
                $display("FAIL rx_valid: got unexpected pulse with rx_data %h, required none", bus.rx_data);
            end else begin
                e = rx_q.pop_front();
                check("rx_data", bus.rx_data, e);
            end
        end
        if (bus.tx_ack) begin
            if (ack_q.size() == 0) begin
                tests++; fails++;
                $display("FAIL tx_ack: got unexpected pulse with tx_data %h, required none", bus.tx_data);
            end else begin
                e = ack_q.pop_front();
                check("tx_ack_data", bus.tx_data, e);
            end
        end
        if (miso_q.size() != 0) begin
            b = miso_q.pop_front();
            check("miso", {7'd0, bus.miso}, {7'd0, b});
        end
        if (chk_end) begin
            check("rx_q_left", 8'(rx_q.size()), 8'd0);
            check("ack_q_left", 8'(ack_q.size()), 8'd0);
            check("miso_q_left", 8'(miso_q.size()), 8'd0);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic sel(input logic [7:0] tx, input logic v);
        bus.tx_data = tx;
        bus.tx_valid = v;
        if (v) ack_q.push_back(tx);
        bus.cs_n = 1'b0;
        tick(4);
    endtask

    task automatic desel();
        tick(2);
        bus.cs_n = 1'b1;
        tick(4);
        miso_q.push_back(1'b1);
        tick(1);
    endtask

    task automatic xfer(input logic [7:0] mo, input logic [7:0] mi, input logic [7:0] nxt,
                        input logic nv, input int ph, input int nb);
        if (nb == 8) rx_q.push_back(mo);
        for (int i = 0; i < nb; i++) begin
            bus.mosi = mo[7-i];
            tick(ph);
            miso_q.push_back(mi[7-i]);
            bus.sclk = 1'b1;
            tick(ph);
            bus.sclk = 1'b0;
            if (i == 0) begin
                bus.tx_data = nxt;
                bus.tx_valid = nv;
                if (nv && nb == 8) ack_q.push_back(nxt);
            end
        end
    endtask

    initial begin
        bus.sclk = 1'b0; bus.cs_n = 1'b1; bus.mosi = 1'b1;
        bus.tx_data = 8'h00; bus.tx_valid = 1'b0;
        chk_rst = 1'b1;
        tick(3);
        chk_rst = 1'b0;
        n_rst = 1'b1;
        tick(3);
        // single byte with valid response
        sel(8'hA5, 1'b1);
        xfer(8'h40, 8'hA5, 8'h00, 1'b0, 4, 8);
        desel();
        // sclk activity while deselected must be ignored; then fill byte
        for (int i = 0; i < 3; i++) begin bus.sclk = 1'b1; tick(4); bus.sclk = 1'b0; tick(4); end
        sel(8'h00, 1'b0);
        xfer(8'h5A, 8'hFF, 8'h00, 1'b0, 4, 8);
        desel();
        // back-to-back bytes
        sel(8'h01, 1'b1);
        xfer(8'hFF, 8'h01, 8'h3C, 1'b1, 4, 8);
        xfer(8'h00, 8'h3C, 8'h00, 1'b0, 4, 8);
        desel();
        // abort after 5 bits, then fresh selection
        sel(8'hC3, 1'b1);
        xfer(8'h12, 8'hC3, 8'h00, 1'b0, 4, 5);
        desel();
        sel(8'h96, 1'b1);
        xfer(8'h69, 8'h96, 8'h00, 1'b0, 4, 8);
        desel();
        // minimum 3-clk phases over 16 bits
        sel(8'h5C, 1'b1);
        xfer(8'hA3, 8'h5C, 8'hE7, 1'b1, 3, 8);
        xfer(8'h3A, 8'hE7, 8'h00, 1'b0, 3, 8);
        desel();
        // reset mid-byte, released with cs_n still low
        sel(8'h11, 1'b1);
        xfer(8'hF0, 8'h11, 8'h77, 1'b1, 4, 4);
        tick(2);
        @(posedge clk); #3;
        n_rst = 1'b0;
        chk_rst = 1'b1;
        tick(2);
        chk_rst = 1'b0;
        ack_q.push_back(8'h77);
        n_rst = 1'b1;
        tick(3);
        miso_q.push_back(1'b0);
        xfer(8'h81, 8'h77, 8'h00, 1'b0, 4, 8);
        desel();
        tick(10);
        chk_end = 1'b1;
        @(negedge clk); #1;
        chk_end = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/sd_spi_responder.md
SD_SPI_RESPONDER -- requirements
Module: sd_spi_responder

Interface
REQ-001 SHALL have port clk, input, 1, system clock; all logic on its rising edge.
REQ-002 SHALL have port n_rst, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port sclk, input, 1, SPI clock from host; asynchronous to clk, mode 0, idle low.
REQ-004 SHALL have port cs_n, input, 1, active-low chip select from host; asynchronous to clk.
REQ-005 SHALL have port mosi, input, 1, serial data from host, MSB first.
REQ-006 SHALL have port miso, output, 1, serial data to host, MSB first.
REQ-007 SHALL have port tx_data, input, 8, next response byte.
REQ-008 SHALL have port tx_valid, input, 1, tx_data holds a byte to send.
REQ-009 SHALL have port tx_ack, output, 1, one-cycle pulse: tx_data consumed.
REQ-010 SHALL have port rx_data, output, 8, last complete byte received.
REQ-011 SHALL have port rx_valid, output, 1, one-cycle pulse: rx_data updated.
REQ-012 SHALL have parameter FILL_BYTE, default 8'hFF, byte sent when tx_valid is low at a load point.

Function
REQ-013 SHALL pass sclk, cs_n and mosi through 2-flop synchronizers; sclk edges detected from synchronized value vs. one further register.
REQ-014 SHALL implement FSM states IDLE and ACTIVE; IDLE->ACTIVE when synchronized cs_n low, ACTIVE->IDLE when synchronized cs_n high.
REQ-015 SHALL, on IDLE->ACTIVE transition, perform a load point: tx shift register <= tx_data and tx_ack pulse if tx_valid, else FILL_BYTE with no tx_ack.
REQ-016 SHALL drive miso = tx shift register bit 7 in ACTIVE, and 1 in IDLE.
REQ-017 SHALL, on each detected sclk rising edge in ACTIVE, shift synchronized mosi into rx shift register LSB and increment 3-bit bit counter (wraps 7->0).
REQ-018 SHALL, on the rising edge that wraps the counter to 0, register the assembled byte into rx_data and pulse rx_valid the next clk cycle (2 clk after the clk edge that first samples sclk high).
REQ-019 SHALL set a load_pending flag on the counter-wrap rising edge; the next detected sclk falling edge is a load point (REQ-015 rules) and clears load_pending.
REQ-020 SHALL, on every other detected sclk falling edge in ACTIVE, shift tx shift register left by one, filling 1.
REQ-021 SHALL ignore sclk edges in IDLE; rx_data holds its last value in IDLE.
REQ-022 SHALL, on cs_n deassertion mid-byte, discard the partial byte (no rx_valid), clear counter and load_pending; a byte already acked is not re-sent.
REQ-023 SHALL give cs_n deassertion priority over a same-cycle sclk edge.
REQ-024 SHALL support back-to-back bytes with no gap while cs_n stays low.
REQ-025 SHALL require sclk high and low phases of at least 3 clk cycles each; behaviour below that is undefined.

Reset
REQ-026 SHALL on n_rst low asynchronously set: state IDLE, miso 1, tx_ack 0, rx_valid 0, rx_data 8'h00, counter 0, load_pending 0, shift registers 8'hFF, synchronizers to idle levels (sclk 0, cs_n 1, mosi 1).
REQ-027 SHALL, after reset release with cs_n already low, enter ACTIVE and perform a load point within 3 clk cycles.

Structure
REQ-028 SHALL take the state enum and byte-width constant 8 from shared package sd_spi_pkg.
REQ-029 SHALL instantiate sub-module spi_edge_sync (2-flop sync plus edge register, outputs sync value, rise, fall) for sclk; cs_n and mosi use same module with unused edge outputs.

Verification
REQ-030 SHALL cover: cs_n low, tx_data 8'hA5 valid, host clocks 8 bits of mosi 8'h40 -> miso bits 1,0,1,0,0,1,0,1; rx_data 8'h40 with one rx_valid; one tx_ack.
REQ-031 SHALL cover: tx_valid low at load point -> miso shows 8'hFF, no tx_ack.
REQ-032 SHALL cover: two back-to-back bytes, tx 8'h01 then 8'h3C, mosi 8'hFF then 8'h00 -> two rx_valid pulses with 8'hFF, 8'h00; two tx_ack; miso correct across boundary.
REQ-033 SHALL cover: cs_n high after 5 sclk rising edges -> no rx_valid, miso 1, next selection starts at bit 7 of a freshly loaded byte.
REQ-034 SHALL cover: n_rst asserted mid-byte -> all outputs at REQ-026 values immediately, no rx_valid after release.
REQ-035 SHALL cover: sclk phases of exactly 3 clk cycles for 16 bits -> no missed or duplicated bits.
